sgmii_rate_adapt: RTL and testbench
===================================

# sgmii_rate_adapt

Single-clock SGMII rate adaptation layer between the MAC-side GMII byte stream and the 125 MHz SGMII-side GMII stream that feeds the TX/RX buffers and 8b/10b coders. At 1000 Mb/s it is a one-cycle register stage. At 100 and 10 Mb/s it replicates each TX byte 10x or 100x, decimates RX bytes by the same factor, and gives the MAC one-cycle byte strobes. It generalises the fixed-speed TBI path to run-time speed selection from the negotiated config word.

## Interface
- FACTOR_100, 10, replication factor at 100 Mb/s (>=2, even)
- FACTOR_10, 100, replication factor at 10 Mb/s (>=2, even, <=255)
- clk_125mhz  input  1  sole clock
- rst  input  1  synchronous, active-high reset
- autoneg_complete  input  1  link up; low forces idle
- speed  input  2  negotiated speed (config bits [11:10]): 2'b10=1000, 2'b01=100, 2'b00=10, 2'b11 treated as 1000
- mac_txd / mac_tx_en / mac_tx_err  input  8/1/1  MAC TX byte, sampled on mac_tx_strobe
- mac_tx_strobe  output  1  MAC must present next TX byte this cycle
- gmii_txd / gmii_tx_en / gmii_tx_err  output  8/1/1  SGMII-side TX, valid every cycle
- gmii_rxd / gmii_rx_dv / gmii_rx_err  input  8/1/1  SGMII-side RX, valid every cycle
- mac_rxd / mac_rx_dv / mac_rx_err  output  8/1/1  decimated RX byte, updated with mac_rx_strobe
- mac_rx_strobe  output  1  one-cycle pulse: new RX byte on mac_rx*
- rep_err_cnt  output  8  saturating count of RX replication mismatches

## Operation
- Active factor N: 1 (1000), FACTOR_100, FACTOR_10. speed_active register, reset 2'b10.
- speed_active loads speed only when tx_busy (hold register tx_en) and rx_busy (gmii_rx_dv registered) are both low; change mid-frame is deferred until both idle. On load, tx_cnt and rx_cnt clear to 0.
- autoneg_complete low: tx_cnt/rx_cnt held 0, strobes low, gmii_tx_* and mac_rx_* driven 0; rep_err_cnt retained.
- TX: tx_cnt counts 0..N-1 and wraps. mac_tx_strobe = (tx_cnt==0) & autoneg_complete, combinational from the register. On a strobe cycle mac_tx_* captured into hold register; hold register drives gmii_tx_* for the next N cycles. N=1: strobe continuously high.
- RX: rx_cnt counts 0..N-1 and wraps; a gmii_rx_dv rising edge (dv=1, previous dv=0) loads rx_cnt=0 that cycle, resynchronising the window. Sample point rx_cnt==N/2 (N=1: every cycle). At sample point gmii_rx* captured to mac_rx*, mac_rx_strobe pulses next cycle with the data. Between sample points mac_rx* hold.
- Strobes continue during idle (dv=0) so the MAC sees idle bytes at line rate.

## Timing
- Reset: all outputs 0, counters 0, speed_active 1000, rep_err_cnt 0.
- TX latency: byte sampled on strobe cycle t appears on gmii_txd at t+1 through t+N.
- RX latency: dv rise at cycle t; first mac_rx_strobe at t+N/2+1 (N=1: t+1).
- Simultaneous dv rise and speed load: speed load wins, rx_cnt=0, dv edge reprocessed against new N next window.
- Reset asserted mid-frame: next cycle all outputs 0; in-progress byte discarded.
- rep_err_cnt saturates at 8'hFF, never wraps.

## Configuration
- SGMII_RATE_ADAPT_RX_CHECK_EN defined: for N>1, each cycle with dv high and rx_cnt!=0 compares gmii_rx* with previous cycle; mismatch sets sticky flag, cleared at window start (rx_cnt==0). If flag set at sample point (including same-cycle mismatch), mac_rx_err forced 1 for that byte and rep_err_cnt increments by 1.
- Undefined: no comparison, mac_rx_err = sampled gmii_rx_err, rep_err_cnt tied 0.

## Test plan
- 1000 Mb/s: mac bytes 0x55,0xD5,0x01 with tx_en, strobe always high -> gmii_txd 0x55,0xD5,0x01 on consecutive cycles, one-cycle delay; RX mirror with strobe every cycle.
- 100 Mb/s: mac byte 0xA5 on strobe -> gmii_txd=0xA5 exactly 10 cycles, strobe every 10th cycle; RX 0x3C replicated 10x after dv rise at t -> mac_rxd=0x3C, strobe at t+6.
- 10 Mb/s: 4-byte frame -> each byte 100 cycles on gmii_txd, 400 cycles tx_en; RX decimation yields 4 strobes with dv=1.
- speed 10->01 during TX frame -> change deferred until tx_en/rx_dv low, then 10-cycle spacing; 2'b11 -> behaves as 1000.
- RX_CHECK_EN, 100 Mb/s: cycle 3 of window carries 0xFF instead of 0x3C -> mac_rx_err=1 for that byte, rep_err_cnt 0->1; 300 mismatching windows -> rep_err_cnt=0xFF.
- autoneg_complete dropped mid-frame, then rst pulse -> outputs 0 next cycle, strobes stop, counters 0.

Source files
------------

// File: rtl/sgmii_rate_adapt.sv
// SGMII rate adaptation: 1x/10x/100x TX byte replication and RX decimation on one 125 MHz clock.
// Optional RX replication checking is enabled by defining SGMII_RATE_ADAPT_RX_CHECK_EN.
module sgmii_rate_adapt #(
  parameter int FACTOR_100 = 10,
  parameter int FACTOR_10  = 100
) (
  input  logic       clk_125mhz,
  input  logic       rst,
  input  logic       autoneg_complete,
  input  logic [1:0] speed,
  input  logic [7:0] mac_txd,
  input  logic       mac_tx_en,
  input  logic       mac_tx_err,
  output logic       mac_tx_strobe,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_err,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_err,
  output logic [7:0] mac_rxd,
  output logic       mac_rx_dv,
  output logic       mac_rx_err,
  output logic       mac_rx_strobe,
  output logic [7:0] rep_err_cnt
);

  localparam logic [7:0] N100_C = 8'(FACTOR_100);
  localparam logic [7:0] N10_C  = 8'(FACTOR_10);

  // 2'b11 is an unused config encoding and behaves as gigabit
  function automatic logic [1:0] map_speed(input logic [1:0] s);
    logic [1:0] m;
    case (s)
      2'b11:   m = 2'b10;
      default: m = s;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] factor_of(input logic [1:0] s);
    logic [7:0] f;
    case (s)
      2'b01:   f = N100_C;
      2'b00:   f = N10_C;
      default: f = 8'd1;
    endcase
    return f;
  endfunction

  logic [1:0] speed_active_r;
  logic [7:0] tx_cnt_r, rx_cnt_r;
  logic [7:0] tx_hold_d_r;
  logic       tx_hold_en_r, tx_hold_err_r;
  logic       rx_dv_prev_r;
  logic [7:0] mac_rxd_r;
  logic       mac_rx_dv_r, mac_rx_err_r, mac_rx_strobe_r;

  logic [7:0] n_s, half_s, rx_cnt_eff_s, tx_cnt_nxt_s, rx_cnt_nxt_s;
  logic       load_s, dv_rise_s, tx_strobe_s, sample_s;
  logic       rx_err_sel_s, cnt_inc_s;

`ifdef SGMII_RATE_ADAPT_RX_CHECK_EN
  logic [8:0] rx_prev_r;
  logic       chk_flag_r;
  logic [7:0] rep_err_cnt_r;
  logic       mismatch_s, bad_s;
`endif

  // Datapath control: active factor, speed load, counter advance and RX sample point
  always_comb begin
    n_s          = factor_of(speed_active_r);
    half_s       = n_s >> 1;
    load_s       = (map_speed(speed) != speed_active_r) & ~tx_hold_en_r & ~rx_dv_prev_r;
    dv_rise_s    = gmii_rx_dv & ~rx_dv_prev_r;
    tx_strobe_s  = (tx_cnt_r == 8'd0) & autoneg_complete & ~rst;
    rx_err_sel_s = gmii_rx_err;
    cnt_inc_s    = 1'b0;
    if (dv_rise_s) begin
      rx_cnt_eff_s = 8'd0;
    end else begin
      rx_cnt_eff_s = rx_cnt_r;
    end
    if (tx_cnt_r == n_s - 8'd1) begin
      tx_cnt_nxt_s = 8'd0;
    end else begin
      tx_cnt_nxt_s = tx_cnt_r + 8'd1;
    end
    if (rx_cnt_eff_s == n_s - 8'd1) begin
      rx_cnt_nxt_s = 8'd0;
    end else begin
      rx_cnt_nxt_s = rx_cnt_eff_s + 8'd1;
    end
    sample_s = autoneg_complete & ~load_s & (rx_cnt_eff_s == half_s);
`ifdef SGMII_RATE_ADAPT_RX_CHECK_EN
    mismatch_s = (n_s != 8'd1) & gmii_rx_dv & (rx_cnt_eff_s != 8'd0)
                 & ({gmii_rx_err, gmii_rxd} != rx_prev_r);
    // sample point is never window start for N>1, so the sticky flag is valid here
    bad_s = (n_s != 8'd1) & (chk_flag_r | mismatch_s);
    if (bad_s) begin
      rx_err_sel_s = 1'b1;
      cnt_inc_s    = sample_s & (rep_err_cnt_r != 8'hFF);
    end else begin
      rx_err_sel_s = gmii_rx_err;
      cnt_inc_s    = 1'b0;
    end
`endif
  end

  // Speed selection and TX replication
  always_ff @(posedge clk_125mhz) begin
    if (rst) begin
      speed_active_r <= 2'b10;
      tx_cnt_r       <= 8'd0;
      tx_hold_d_r    <= 8'd0;
      tx_hold_en_r   <= 1'b0;
      tx_hold_err_r  <= 1'b0;
    end else begin
      if (load_s) begin
        speed_active_r <= map_speed(speed);
      end
      if (!autoneg_complete) begin
        tx_cnt_r      <= 8'd0;
        tx_hold_d_r   <= 8'd0;
        tx_hold_en_r  <= 1'b0;
        tx_hold_err_r <= 1'b0;
      end else begin
        tx_cnt_r <= load_s ? 8'd0 : tx_cnt_nxt_s;
        if (tx_strobe_s) begin
          tx_hold_d_r   <= mac_txd;
          tx_hold_en_r  <= mac_tx_en;
          tx_hold_err_r <= mac_tx_err;
        end
      end
    end
  end

  // RX window tracking and decimation
  always_ff @(posedge clk_125mhz) begin
    if (rst) begin
      rx_cnt_r        <= 8'd0;
      rx_dv_prev_r    <= 1'b0;
      mac_rxd_r       <= 8'd0;
      mac_rx_dv_r     <= 1'b0;
      mac_rx_err_r    <= 1'b0;
      mac_rx_strobe_r <= 1'b0;
    end else begin
      rx_dv_prev_r <= gmii_rx_dv;
      if (!autoneg_complete) begin
        rx_cnt_r        <= 8'd0;
        mac_rxd_r       <= 8'd0;
        mac_rx_dv_r     <= 1'b0;
        mac_rx_err_r    <= 1'b0;
        mac_rx_strobe_r <= 1'b0;
      end else begin
        rx_cnt_r        <= load_s ? 8'd0 : rx_cnt_nxt_s;
        mac_rx_strobe_r <= sample_s;
        if (sample_s) begin
          mac_rxd_r    <= gmii_rxd;
          mac_rx_dv_r  <= gmii_rx_dv;
          mac_rx_err_r <= rx_err_sel_s;
        end
      end
    end
  end

`ifdef SGMII_RATE_ADAPT_RX_CHECK_EN
  // Replication checker state: previous RX symbol, sticky mismatch flag, saturating counter
  always_ff @(posedge clk_125mhz) begin
    if (rst) begin
      rx_prev_r     <= 9'd0;
      chk_flag_r    <= 1'b0;
      rep_err_cnt_r <= 8'd0;
    end else begin
      rx_prev_r <= {gmii_rx_err, gmii_rxd};
      if (!autoneg_complete || load_s || rx_cnt_eff_s == 8'd0) begin
        chk_flag_r <= 1'b0;
      end else begin
        chk_flag_r <= chk_flag_r | mismatch_s;
      end
      if (autoneg_complete && cnt_inc_s) begin
        rep_err_cnt_r <= rep_err_cnt_r + 8'd1;
      end
    end
  end

  assign rep_err_cnt = rep_err_cnt_r;
`else
  assign rep_err_cnt = 8'h00;
`endif

  assign mac_tx_strobe = tx_strobe_s;
  assign gmii_txd      = tx_hold_d_r;
  assign gmii_tx_en    = tx_hold_en_r;
  assign gmii_tx_err   = tx_hold_err_r;
  assign mac_rxd       = mac_rxd_r;
  assign mac_rx_dv     = mac_rx_dv_r;
  assign mac_rx_err    = mac_rx_err_r;
  assign mac_rx_strobe = mac_rx_strobe_r;

endmodule

// File: tb/tb_sgmii_rate_adapt.sv
// Directed self-checking bench for sgmii_rate_adapt: speeds 1000/100/10, deferred speed
// change, autoneg drop, reset, and replication checking when SGMII_RATE_ADAPT_RX_CHECK_EN is set.
module tb_sgmii_rate_adapt;

  logic       clk = 1'b0;
  logic       rst, autoneg_complete;
  logic [1:0] speed;
  logic [7:0] mac_txd;
  logic       mac_tx_en, mac_tx_err, mac_tx_strobe;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en, gmii_tx_err;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv, gmii_rx_err;
  logic [7:0] mac_rxd;
  logic       mac_rx_dv, mac_rx_err, mac_rx_strobe;
  logic [7:0] rep_err_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int rx_seen;
  logic [7:0] tx_frame [4];
  logic [7:0] exp_rep_hold;

  always #4 clk = ~clk;

  sgmii_rate_adapt #(.FACTOR_100(10), .FACTOR_10(100)) dut (
    .clk_125mhz(clk), .rst(rst), .autoneg_complete(autoneg_complete), .speed(speed),
    .mac_txd(mac_txd), .mac_tx_en(mac_tx_en), .mac_tx_err(mac_tx_err),
    .mac_tx_strobe(mac_tx_strobe),
    .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_err(gmii_tx_err),
    .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_err(gmii_rx_err),
    .mac_rxd(mac_rxd), .mac_rx_dv(mac_rx_dv), .mac_rx_err(mac_rx_err),
    .mac_rx_strobe(mac_rx_strobe), .rep_err_cnt(rep_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one 10-cycle replicated RX window of 0x3C; optional 0xFF at window cycle 3
  task automatic rx_window(input logic corrupt, input logic err);
    for (int c = 0; c < 10; c++) begin
      gmii_rxd    = (corrupt && c == 3) ? 8'hFF : 8'h3C;
      gmii_rx_dv  = 1'b1;
      gmii_rx_err = err;
      step();
    end
  endtask

  initial begin
    tx_frame[0] = 8'h10; tx_frame[1] = 8'h21; tx_frame[2] = 8'h32; tx_frame[3] = 8'h43;
    rst = 1'b1; autoneg_complete = 1'b0; speed = 2'b10;
    mac_txd = 8'h00; mac_tx_en = 1'b0; mac_tx_err = 1'b0;
    gmii_rxd = 8'h00; gmii_rx_dv = 1'b0; gmii_rx_err = 1'b0;
    step(); step();
    chk("rst_gmii_txd", gmii_txd, 8'h00);
    chk("rst_tx_en", gmii_tx_en, 1'b0);
    chk("rst_tx_strobe", mac_tx_strobe, 1'b0);
    chk("rst_rx_strobe", mac_rx_strobe, 1'b0);
    chk("rst_rep_cnt", rep_err_cnt, 8'h00);

    // 1000 Mb/s TX: one-cycle delay, strobe always high
    rst = 1'b0; autoneg_complete = 1'b1;
    step();
    chk("g_strobe0", mac_tx_strobe, 1'b1);
    mac_txd = 8'h55; mac_tx_en = 1'b1;
    step();
    chk("g_txd55", gmii_txd, 8'h55); chk("g_txen", gmii_tx_en, 1'b1);
    chk("g_strobe1", mac_tx_strobe, 1'b1);
    mac_txd = 8'hD5;
    step();
    chk("g_txdD5", gmii_txd, 8'hD5);
    mac_txd = 8'h01;
    step();
    chk("g_txd01", gmii_txd, 8'h01);
    mac_txd = 8'h00; mac_tx_en = 1'b0;
    step();
    chk("g_txen_off", gmii_tx_en, 1'b0);

    // 1000 Mb/s RX mirror
    gmii_rxd = 8'h11; gmii_rx_dv = 1'b1;
    step();
    chk("g_rx_strobe", mac_rx_strobe, 1'b1); chk("g_rxd11", mac_rxd, 8'h11);
    chk("g_rxdv", mac_rx_dv, 1'b1);
    gmii_rxd = 8'h22;
    step();
    chk("g_rxd22", mac_rxd, 8'h22); chk("g_rx_strobe2", mac_rx_strobe, 1'b1);
    gmii_rxd = 8'h00; gmii_rx_dv = 1'b0;
    step();
    chk("g_rxdv_idle", mac_rx_dv, 1'b0); chk("g_rx_strobe_idle", mac_rx_strobe, 1'b1);

    // switch to 100 Mb/s while idle
    speed = 2'b01;
    step();
    chk("h_strobe_load", mac_tx_strobe, 1'b1);
    mac_txd = 8'hA5; mac_tx_en = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step();
      if (i <= 10) begin
        chk("h_txdA5", gmii_txd, 8'hA5);
        chk("h_txen", gmii_tx_en, 1'b1);
        chk("h_strobe", mac_tx_strobe, (i == 10));
      end else begin
        chk("h_txd_end", gmii_txd, 8'h00);
        chk("h_txen_end", gmii_tx_en, 1'b0);
      end
      if (i == 1) begin
        mac_txd = 8'h00; mac_tx_en = 1'b0;
      end
    end

    // 100 Mb/s RX: dv rise at t, strobe with data at t+6, next idle strobe at t+16
    gmii_rxd = 8'h3C; gmii_rx_dv = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("h_rx_strobe", mac_rx_strobe, (k == 6 || k == 16));
      if (k == 6) begin
        chk("h_rxd3C", mac_rxd, 8'h3C); chk("h_rxdv", mac_rx_dv, 1'b1);
      end
      if (k == 16) chk("h_rxdv_idle", mac_rx_dv, 1'b0);
      if (k == 10) begin
        gmii_rxd = 8'h00; gmii_rx_dv = 1'b0;
      end
    end

    // 10 Mb/s frame with a speed change requested mid-frame
    speed = 2'b00;
    step();
    chk("t_strobe_load", mac_tx_strobe, 1'b1);
    mac_txd = tx_frame[0]; mac_tx_en = 1'b1;
    gmii_rxd = 8'h5A; gmii_rx_dv = 1'b1;
    rx_seen = 0;
    for (int j = 1; j <= 400; j++) begin
      step();
      chk("t_txd", gmii_txd, tx_frame[(j - 1) / 100]);
      chk("t_txen", gmii_tx_en, 1'b1);
      chk("t_strobe", mac_tx_strobe, (j % 100 == 0));
      chk("t_rx_strobe", mac_rx_strobe, (j % 100 == 51));
      if (mac_rx_strobe && mac_rx_dv && mac_rxd == 8'h5A) rx_seen++;
      if (j == 1) speed = 2'b01;
      if (j % 100 == 0 && j < 400) mac_txd = tx_frame[j / 100];
      if (j == 400) begin
        mac_txd = 8'h00; mac_tx_en = 1'b0; gmii_rxd = 8'h00; gmii_rx_dv = 1'b0;
      end
    end
    chk("t_rx_count", rx_seen, 4);
    step();
    chk("d_strobe_401", mac_tx_strobe, 1'b0); chk("d_txen_401", gmii_tx_en, 1'b0);
    step();
    chk("d_strobe_402", mac_tx_strobe, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("d_strobe_100", mac_tx_strobe, (i == 10));
    end

    // 2'b11 behaves as 1000
    speed = 2'b11;
    step();
    chk("x_strobe0", mac_tx_strobe, 1'b1);
    mac_txd = 8'h77; mac_tx_en = 1'b1;
    step();
    chk("x_txd77", gmii_txd, 8'h77); chk("x_strobe1", mac_tx_strobe, 1'b1);
    mac_txd = 8'h88;
    step();
    chk("x_txd88", gmii_txd, 8'h88); chk("x_strobe2", mac_tx_strobe, 1'b1);
    mac_txd = 8'h00; mac_tx_en = 1'b0;
    step();

    // replication check windows at 100 Mb/s
    speed = 2'b01;
    step();
    step();
`ifdef SGMII_RATE_ADAPT_RX_CHECK_EN
    rx_window(1'b1, 1'b0);
    chk("c_err_forced", mac_rx_err, 1'b1); chk("c_rxd", mac_rxd, 8'h3C);
    chk("c_cnt1", rep_err_cnt, 8'h01);
    rx_window(1'b0, 1'b0);
    chk("c_err_clean", mac_rx_err, 1'b0); chk("c_cnt_hold", rep_err_cnt, 8'h01);
    for (int w = 0; w < 254; w++) rx_window(1'b1, 1'b0);
    chk("c_cnt_ff", rep_err_cnt, 8'hFF);
    for (int w = 0; w < 46; w++) rx_window(1'b1, 1'b0);
    chk("c_cnt_sat", rep_err_cnt, 8'hFF);
    exp_rep_hold = 8'hFF;
`else
    rx_window(1'b1, 1'b0);
    chk("c_err_pass", mac_rx_err, 1'b0); chk("c_rxd", mac_rxd, 8'h3C);
    chk("c_cnt0", rep_err_cnt, 8'h00);
    rx_window(1'b0, 1'b1);
    chk("c_err_follow", mac_rx_err, 1'b1); chk("c_cnt0b", rep_err_cnt, 8'h00);
    exp_rep_hold = 8'h00;
`endif
    gmii_rxd = 8'h00; gmii_rx_dv = 1'b0; gmii_rx_err = 1'b0;
    step(); step();

    // autoneg drop mid-frame, then reset
    mac_txd = 8'h99; mac_tx_en = 1'b1; gmii_rxd = 8'h44; gmii_rx_dv = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("a_txd99", gmii_txd, 8'h99); chk("a_rxd44", mac_rxd, 8'h44);
    autoneg_complete = 1'b0;
    step();
    chk("a_txd0", gmii_txd, 8'h00); chk("a_txen0", gmii_tx_en, 1'b0);
    chk("a_tx_strobe0", mac_tx_strobe, 1'b0); chk("a_rx_strobe0", mac_rx_strobe, 1'b0);
    chk("a_rxd0", mac_rxd, 8'h00); chk("a_rxdv0", mac_rx_dv, 1'b0);
    chk("a_rep_keep", rep_err_cnt, exp_rep_hold);
    for (int i = 0; i < 15; i++) step();
    chk("a_tx_strobe_stay", mac_tx_strobe, 1'b0); chk("a_rx_strobe_stay", mac_rx_strobe, 1'b0);
    rst = 1'b1;
    step();
    chk("a_rep_rst", rep_err_cnt, 8'h00);

    // reset asserted mid-frame at 1000 Mb/s
    speed = 2'b10; rst = 1'b0; autoneg_complete = 1'b1;
    mac_txd = 8'h66; mac_tx_en = 1'b1; gmii_rxd = 8'h66; gmii_rx_dv = 1'b1;
    step(); step();
    chk("r_txd66", gmii_txd, 8'h66); chk("r_rxd66", mac_rxd, 8'h66);
    rst = 1'b1;
    step();
    chk("r_txd0", gmii_txd, 8'h00); chk("r_txen0", gmii_tx_en, 1'b0);
    chk("r_rxd0", mac_rxd, 8'h00); chk("r_rx_strobe0", mac_rx_strobe, 1'b0);
    chk("r_tx_strobe0", mac_tx_strobe, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
